// File: rtl/br_svc_mc_ni.sv
// br_svc_mc_ni: multi-channel BrLite service NI with per-channel TX/RX FIFOs, a CPU
// register window and a round-robin TX arbiter. Optional macro: BR_RX_TIMESTAMP_EN.
module br_svc_mc_ni #(
    parameter int N_CH     = 2,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int ADDR_W   = $clog2(N_CH) + 3,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_en_i,
    input  logic [3:0]          cfg_we_i,
    input  logic [ADDR_W-1:0]   cfg_addr_i,
    input  logic [31:0]         cfg_data_i,
    output logic [31:0]         cfg_data_o,
    output logic                irq_o,
    input  logic [N_CH-1:0]     br_rx_i,
    output logic [N_CH-1:0]     br_ack_o,
    input  logic [4*N_CH-1:0]   br_ksvc_i,
    input  logic [32*N_CH-1:0]  br_data_i,
    input  logic                br_local_busy_i,
    output logic                br_req_o,
    input  logic                br_ack_i,
    output logic [3:0]          br_ksvc_o,
    output logic [15:0]         br_payload_o,
    output logic [CH_W-1:0]     br_chan_o,
    input  logic [31:0]         timestamp_i
);
    localparam int TXP_W = $clog2(TX_DEPTH);
    localparam int TXC_W = TXP_W + 1;
    localparam int RXP_W = $clog2(RX_DEPTH);
    localparam int RXC_W = RXP_W + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t r_state, w_state_nxt;

    logic [19:0]      r_tx_mem [N_CH][TX_DEPTH];
    logic [TXP_W-1:0] r_tx_wp [N_CH];
    logic [TXP_W-1:0] r_tx_rp [N_CH];
    logic [TXC_W-1:0] r_tx_cnt [N_CH];
    logic [15:0]      r_tx_stage [N_CH];
    logic [35:0]      r_rx_mem [N_CH][RX_DEPTH];
`ifdef BR_RX_TIMESTAMP_EN
    logic [31:0]      r_rx_ts [N_CH][RX_DEPTH];
`endif
    logic [RXP_W-1:0] r_rx_wp [N_CH];
    logic [RXP_W-1:0] r_rx_rp [N_CH];
    logic [RXC_W-1:0] r_rx_cnt [N_CH];
    logic [2:0]       r_irq_en [N_CH];
    logic [N_CH-1:0]  r_tx_done, r_tx_ovf, r_br_ack;

    logic             r_br_req;
    logic [3:0]       r_br_ksvc;
    logic [15:0]      r_br_payload;
    logic [CH_W-1:0]  r_br_chan, r_ptr;
    logic [31:0]      r_cfg_data, w_rd_data;

    logic [ADDR_W-1:0] w_ch_sel;
    logic [2:0]        w_reg;
    logic              w_map, w_wr, w_rd_any, w_rd;
    logic [N_CH-1:0]   w_sel, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [N_CH-1:0]   w_tx_push_req, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [N_CH-1:0]   w_w1c_done, w_w1c_ovf, w_irq;
    logic              w_gnt_vld, w_grant;
    logic [CH_W-1:0]   w_gnt_ch;
    logic              w_unused;

    function automatic logic [CH_W-1:0] f_rr(input logic [CH_W-1:0] base, input int off);
        return CH_W'((int'(base) + off) % N_CH);
    endfunction

    assign w_ch_sel = cfg_addr_i >> 3;
    assign w_reg    = cfg_addr_i[2:0];
    assign w_map    = (w_ch_sel < ADDR_W'(N_CH));
    assign w_wr     = cfg_en_i && (cfg_we_i != 4'b0000) && w_map;
    assign w_rd_any = cfg_en_i && (cfg_we_i == 4'b0000);
    assign w_rd     = w_rd_any && w_map;

    // A pop in the same cycle frees a slot, so both FIFOs accept a push when full.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_sel[c]         = w_map && (w_ch_sel == ADDR_W'(c));
            w_tx_full[c]     = (r_tx_cnt[c] == TXC_W'(TX_DEPTH));
            w_tx_empty[c]    = (r_tx_cnt[c] == '0);
            w_rx_full[c]     = (r_rx_cnt[c] == RXC_W'(RX_DEPTH));
            w_rx_empty[c]    = (r_rx_cnt[c] == '0);
            w_tx_pop[c]      = (r_state == S_REQ) && br_ack_i && (r_br_chan == CH_W'(c));
            w_tx_push_req[c] = w_wr && w_sel[c] && (w_reg == 3'd4) && cfg_we_i[0];
            w_tx_push[c]     = w_tx_push_req[c] && (!w_tx_full[c] || w_tx_pop[c]);
            w_rx_pop[c]      = w_rd && w_sel[c] && (w_reg == 3'd6) && !w_rx_empty[c];
            w_rx_push[c]     = br_rx_i[c] && !r_br_ack[c] && (!w_rx_full[c] || w_rx_pop[c]);
            w_w1c_done[c]    = w_wr && w_sel[c] && (w_reg == 3'd2) && cfg_we_i[0] && cfg_data_i[1];
            w_w1c_ovf[c]     = w_wr && w_sel[c] && (w_reg == 3'd2) && cfg_we_i[0] && cfg_data_i[2];
            w_irq[c]         = |({r_tx_ovf[c], r_tx_done[c], !w_rx_empty[c]} & r_irq_en[c]);
        end
    end

    // r_ptr holds the highest-priority channel: one past the last one granted.
    always_comb begin
        w_gnt_vld   = 1'b0;
        w_gnt_ch    = '0;
        w_grant     = 1'b0;
        w_state_nxt = r_state;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_gnt_vld && !w_tx_empty[f_rr(r_ptr, i)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = f_rr(r_ptr, i);
            end
        end
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld && !br_local_busy_i) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (br_ack_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_br_req     <= 1'b0;
            r_br_ksvc    <= '0;
            r_br_payload <= '0;
            r_br_chan    <= '0;
            r_ptr        <= '0;
        end else if (w_grant) begin
            r_br_req                   <= 1'b1;
            {r_br_ksvc, r_br_payload}  <= r_tx_mem[w_gnt_ch][r_tx_rp[w_gnt_ch]];
            r_br_chan                  <= w_gnt_ch;
            r_ptr                      <= f_rr(w_gnt_ch, 1);
        end else if ((r_state == S_REQ) && br_ack_i) begin
            r_br_req <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                r_tx_wp[c]  <= '0;
                r_tx_rp[c]  <= '0;
                r_tx_cnt[c] <= '0;
                r_rx_wp[c]  <= '0;
                r_rx_rp[c]  <= '0;
                r_rx_cnt[c] <= '0;
                r_irq_en[c] <= '0;
            end
            r_tx_done <= '0;
            r_tx_ovf  <= '0;
            r_br_ack  <= '0;
        end else begin
            r_br_ack <= w_rx_push;
            for (int c = 0; c < N_CH; c++) begin
                if (w_tx_push[c]) r_tx_wp[c] <= r_tx_wp[c] + TXP_W'(1);
                if (w_tx_pop[c])  r_tx_rp[c] <= r_tx_rp[c] + TXP_W'(1);
                r_tx_cnt[c] <= r_tx_cnt[c] + TXC_W'(w_tx_push[c]) - TXC_W'(w_tx_pop[c]);
                if (w_rx_push[c]) r_rx_wp[c] <= r_rx_wp[c] + RXP_W'(1);
                if (w_rx_pop[c])  r_rx_rp[c] <= r_rx_rp[c] + RXP_W'(1);
                r_rx_cnt[c] <= r_rx_cnt[c] + RXC_W'(w_rx_push[c]) - RXC_W'(w_rx_pop[c]);
                if (w_wr && w_sel[c] && (w_reg == 3'd1) && cfg_we_i[0])
                    r_irq_en[c] <= cfg_data_i[2:0];
                // Set has priority over a same-cycle W1C.
                r_tx_done[c] <= w_tx_pop[c] | (r_tx_done[c] & ~w_w1c_done[c]);
                r_tx_ovf[c]  <= (w_tx_push_req[c] & ~w_tx_push[c]) | (r_tx_ovf[c] & ~w_w1c_ovf[c]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < N_CH; c++) begin
            if (w_tx_push[c]) r_tx_mem[c][r_tx_wp[c]] <= {cfg_data_i[3:0], r_tx_stage[c]};
            if (w_wr && w_sel[c] && (w_reg == 3'd3)) begin
                if (cfg_we_i[0]) r_tx_stage[c][7:0]  <= cfg_data_i[7:0];
                if (cfg_we_i[1]) r_tx_stage[c][15:8] <= cfg_data_i[15:8];
            end
            if (w_rx_push[c]) begin
                r_rx_mem[c][r_rx_wp[c]] <= {br_ksvc_i[4*c +: 4], br_data_i[32*c +: 32]};
`ifdef BR_RX_TIMESTAMP_EN
                r_rx_ts[c][r_rx_wp[c]]  <= timestamp_i;
`endif
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_sel[c]) begin
                case (w_reg)
                    3'd0: begin
                        w_rd_data[7:4]  = 4'(r_tx_cnt[c]);
                        w_rd_data[11:8] = 4'(r_rx_cnt[c]);
                        w_rd_data[0]    = w_tx_full[c];
                        w_rd_data[1]    = w_rx_empty[c];
                        w_rd_data[2]    = br_local_busy_i;
                    end
                    3'd1: w_rd_data[2:0] = r_irq_en[c];
                    3'd2: w_rd_data[2:0] = {r_tx_ovf[c], r_tx_done[c], !w_rx_empty[c]};
                    3'd5: if (!w_rx_empty[c]) w_rd_data[3:0] = r_rx_mem[c][r_rx_rp[c]][35:32];
                    3'd6: if (!w_rx_empty[c]) w_rd_data = r_rx_mem[c][r_rx_rp[c]][31:0];
`ifdef BR_RX_TIMESTAMP_EN
                    3'd7: if (!w_rx_empty[c]) w_rd_data = r_rx_ts[c][r_rx_rp[c]];
`endif
                    default: w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_cfg_data <= '0;
        else if (w_rd_any) r_cfg_data <= w_rd_data;
    end

`ifdef BR_RX_TIMESTAMP_EN
    assign w_unused = ^cfg_data_i[31:16];
`else
    assign w_unused = ^{cfg_data_i[31:16], timestamp_i};
`endif

    assign cfg_data_o   = r_cfg_data;
    assign irq_o        = |w_irq;
    assign br_ack_o     = r_br_ack;
    assign br_req_o     = r_br_req;
    assign br_ksvc_o    = r_br_ksvc;
    assign br_payload_o = r_br_payload;
    assign br_chan_o    = r_br_chan;
endmodule

// File: tb/tb_br_svc_mc_ni.sv
// Scoreboard bench for br_svc_mc_ni: register reads and BrLite transmissions are
// checked by a monitor against queues filled by the directed stimulus.
`timescale 1ns/1ps
module tb_br_svc_mc_ni;
    localparam int N_CH   = 2;
    localparam int ADDR_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_en;
    logic [3:0]         cfg_we;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [31:0]        cfg_wdata, cfg_rdata;
    logic               irq;
    logic [N_CH-1:0]    br_rx, br_ack_out;
    logic [4*N_CH-1:0]  br_ksvc_in;
    logic [32*N_CH-1:0] br_data_in;
    logic               busy, req, ack_in;
    logic [3:0]         ksvc_out;
    logic [15:0]        payload_out;
    logic               chan_out;
    logic [31:0]        ts;

    br_svc_mc_ni #(.N_CH(N_CH), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_en_i(cfg_en), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_wdata), .cfg_data_o(cfg_rdata), .irq_o(irq),
        .br_rx_i(br_rx), .br_ack_o(br_ack_out), .br_ksvc_i(br_ksvc_in), .br_data_i(br_data_in),
        .br_local_busy_i(busy), .br_req_o(req), .br_ack_i(ack_in),
        .br_ksvc_o(ksvc_out), .br_payload_o(payload_out), .br_chan_o(chan_out),
        .timestamp_i(ts)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] val; } rd_exp_t;
    typedef struct { string name; logic [3:0] ksvc; logic [15:0] pay; logic chan; int lat; } tx_exp_t;
    rd_exp_t rd_q[$];
    tx_exp_t tx_q[$];

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   wr_cyc = 0;
    int   ack_cnt = 0;
    logic rd_vld = 1'b0;
    logic prev_req = 1'b0;
    logic ack_auto = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_vld <= cfg_en && (cfg_we == 4'b0000);
    always @(posedge clk) if (br_ack_out[1]) ack_cnt <= ack_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: read data one cycle after each read strobe, TX words on each req rise.
    initial begin
        rd_exp_t e;
        tx_exp_t t;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_q.size()), 32'd1);
                else begin
                    e = rd_q.pop_front();
                    chk(e.name, cfg_rdata, e.val);
                end
            end
            if (req && !prev_req) begin
                if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_q.size()), 32'd1);
                else begin
                    t = tx_q.pop_front();
                    chk({t.name, "_ksvc"}, 32'(ksvc_out), 32'(t.ksvc));
                    chk({t.name, "_payload"}, 32'(payload_out), 32'(t.pay));
                    chk({t.name, "_chan"}, 32'(chan_out), 32'(t.chan));
                    if (t.lat >= 0) chk({t.name, "_latency"}, 32'(cyc - wr_cyc), 32'(t.lat));
                end
            end
            prev_req = req;
        end
    end

    initial begin
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            ack_in = ack_auto && req && !ack_in;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic cfg_wr(input int ch, input int rg, input logic [31:0] d, input logic [3:0] we);
        @(negedge clk);
        cfg_en = 1'b1; cfg_we = we; cfg_addr = ADDR_W'(ch * 8 + rg); cfg_wdata = d;
        if (rg == 4) wr_cyc = cyc;
        @(negedge clk);
        cfg_en = 1'b0; cfg_we = 4'b0000;
    endtask

    task automatic cfg_rd(input int ch, input int rg, input logic [31:0] exp, input string nm);
        @(negedge clk);
        cfg_en = 1'b1; cfg_we = 4'b0000; cfg_addr = ADDR_W'(ch * 8 + rg);
        rd_q.push_back('{nm, exp});
        @(negedge clk);
        cfg_en = 1'b0;
    endtask

    task automatic push_tx(input string nm, input int ch, input logic [3:0] k,
                           input logic [15:0] p, input bit served, input int lat);
        if (served) tx_q.push_back('{nm, k, p, ch[0], lat});
        cfg_wr(ch, 3, {16'h0, p}, 4'b0011);
        cfg_wr(ch, 4, {28'h0, k}, 4'b0001);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while ((tx_q.size() != 0 || req) && k < 200) begin @(negedge clk); k++; end
        chk({nm, "_drain_left"}, 32'(tx_q.size()), 32'd0);
    endtask

    task automatic wait_ack(input int ch, input string nm);
        int k = 0;
        do begin @(negedge clk); k++; end while (!br_ack_out[ch] && k < 20);
        chk(nm, 32'(br_ack_out[ch]), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_we = 4'b0000; cfg_addr = '0; cfg_wdata = '0;
        br_rx = '0; br_ksvc_in = '0; br_data_in = '0; busy = 1'b0; ts = '0;
        repeat (3) @(negedge clk);
        chk("rst_cfg_data", cfg_rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_br_ack", 32'(br_ack_out), 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_ksvc", 32'(ksvc_out), 32'h0);
        chk("rst_payload", 32'(payload_out), 32'h0);
        chk("rst_chan", 32'(chan_out), 32'h0);
        rst = 1'b0;
        cfg_rd(0, 0, 32'h2, "rst_status0");
        cfg_rd(1, 2, 32'h0, "rst_pend1");
        cfg_rd(0, 1, 32'h0, "rst_irq_en0");

        // single transfer with 2-cycle push-to-request latency
        push_tx("t1", 0, 4'h5, 16'h1234, 1'b1, 2);
        wait_drain("t1");
        chk("t1_req_drop", 32'(req), 32'h0);
        cfg_rd(0, 2, 32'h2, "t1_pend_done");

        // round-robin order with entries queued while the router is busy
        do_reset();
        busy = 1'b1;
        push_tx("t2_a", 0, 4'h1, 16'h0101, 1'b1, -1);
        push_tx("t2_b", 1, 4'h2, 16'h0202, 1'b1, -1);
        push_tx("t2_c", 0, 4'h3, 16'h0303, 1'b1, -1);
        push_tx("t2_d", 1, 4'h4, 16'h0404, 1'b1, -1);
        cfg_rd(0, 0, 32'h26, "t2_status0");
        busy = 1'b0;
        wait_drain("t2");
        cfg_rd(1, 2, 32'h2, "t2_pend1");

        // RX backpressure on channel 1
        do_reset();
        @(negedge clk);
        ack_cnt = 0;
        br_ksvc_in[7:4] = 4'h3; br_data_in[63:32] = 32'hAAAA5555; br_rx[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_ack_count", 32'(ack_cnt), 32'd4);
        chk("t3_ack_held", 32'(br_ack_out[1]), 32'h0);
        cfg_rd(1, 0, 32'h400, "t3_status_full");
        cfg_rd(1, 5, 32'h3, "t3_rx_ksvc");
        cfg_rd(1, 6, 32'hAAAA5555, "t3_rx_pop");
        chk("t3_fifth_ack", 32'(br_ack_out[1]), 32'h1);
        br_rx[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_ack_total", 32'(ack_cnt), 32'd5);
        cfg_rd(1, 0, 32'h400, "t3_status_refill");
        for (int i = 0; i < 4; i++) cfg_rd(1, 6, 32'hAAAA5555, "t3_drain");
        cfg_rd(1, 6, 32'h0, "t3_empty_read");
        cfg_rd(1, 0, 32'h2, "t3_status_empty");

        // IRQ on RX non-empty
        cfg_wr(1, 1, 32'h1, 4'b0001);
        chk("t4_irq_idle", 32'(irq), 32'h0);
        br_ksvc_in[7:4] = 4'h7; br_data_in[63:32] = 32'h00010002; br_rx[1] = 1'b1;
        wait_ack(1, "t4_ack");
        br_rx[1] = 1'b0;
        chk("t4_irq_set", 32'(irq), 32'h1);
        cfg_rd(1, 2, 32'h1, "t4_pend_rx");
        cfg_rd(1, 6, 32'h00010002, "t4_pop");
        chk("t4_irq_clr", 32'(irq), 32'h0);
        cfg_wr(1, 1, 32'h0, 4'b0001);

        // TX overflow and W1C
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 5; i++)
            push_tx("t5", 0, 4'(i + 1), 16'(16'h1000 + i), i < 4, -1);
        cfg_rd(0, 0, 32'h47, "t5_status");
        cfg_rd(0, 2, 32'h4, "t5_pend_ovf");
        cfg_wr(0, 2, 32'h4, 4'b0001);
        cfg_rd(0, 2, 32'h0, "t5_pend_clr");
        busy = 1'b0;
        wait_drain("t5");
        cfg_rd(0, 2, 32'h2, "t5_pend_done");

        // RX timestamp
        @(negedge clk);
        ts = 32'd100; br_ksvc_in[3:0] = 4'h9; br_data_in[31:0] = 32'h12345678; br_rx[0] = 1'b1;
        wait_ack(0, "t6_ack");
        br_rx[0] = 1'b0; ts = 32'd200;
`ifdef BR_RX_TIMESTAMP_EN
        cfg_rd(0, 7, 32'd100, "t6_timestamp");
`else
        cfg_rd(0, 7, 32'd0, "t6_timestamp");
`endif
        cfg_rd(0, 6, 32'h12345678, "t6_pop");

        // reset during an outstanding request flushes everything
        ack_auto = 1'b0;
        push_tx("t7", 0, 4'hA, 16'hBEEF, 1'b1, -1);
        push_tx("t7_lost", 0, 4'hB, 16'hCAFE, 1'b0, -1);
        begin
            int k = 0;
            while (!req && k < 20) begin @(negedge clk); k++; end
        end
        chk("t7_req_up", 32'(req), 32'h1);
        rst = 1'b1;
        #1;
        chk("t7_req_abort", 32'(req), 32'h0);
        chk("t7_payload_abort", 32'(payload_out), 32'h0);
        @(negedge clk);
        rst = 1'b0; ack_auto = 1'b1;
        cfg_rd(0, 0, 32'h2, "t7_status_flushed");
        repeat (3) @(negedge clk);

        chk("end_rd_queue", 32'(rd_q.size()), 32'd0);
        chk("end_tx_queue", 32'(tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
